// File: rtl/sram_pkg.sv
// sram_pkg: shared encodings, widths and address-map helper for the SRAM controller.
package sram_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int WORD_W = SRAM_ADDR_W - 1;
  localparam int DEFAULT_BASE_ADDR = 1024;
  function automatic logic [WORD_W-1:0] word_of(input logic [31:0] addr, input logic [31:0] base);
    return WORD_W'((addr - base) >> 2);
  endfunction
endpackage

// File: rtl/sram_phase_counter.sv
// sram_phase_counter: loadable down-counter timing one SRAM half-access.
module sram_phase_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last,
  output logic         weWindow
);
  logic [W-1:0] count_q, count_d;
  always_comb begin
    count_d = load ? load_val : (last ? count_q : count_q - W'(1));
  end
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else count_q <= count_d;
  end
  assign last = count_q == '0;
  assign weWindow = count_q != '0;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: splits a 32-bit word access into two timed 16-bit async SRAM accesses, low half first.
module sram_controller
  import sram_pkg::*;
#(
  parameter int BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wrEn,
  input  logic                   rdEn,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);
  localparam int CW = $clog2(ACCESS_CYCLES);
  state_t state_q, state_d;
  logic dir_wr_q, dir_wr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic req, start, to_hi, last, we_window, active, dq_oe;
  logic [SRAM_DATA_W-1:0] half;
  assign req = wrEn | rdEn;
  assign start = state_q == IDLE && req;
  assign to_hi = state_q == LO && last;
  sram_phase_counter #(.W(CW)) u_cnt (
    .clk(clk), .rst(rst), .load(start | to_hi), .load_val(CW'(ACCESS_CYCLES - 1)),
    .last(last), .weWindow(we_window)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_wr_q <= 1'b0;
      word_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      dir_wr_q <= dir_wr_d;
      word_q <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q <= addr_d;
    end
  end
  // DONE always returns to IDLE so a held request is not re-issued on the advancing edge
  always_comb begin
    state_d = state_q == IDLE ? (req ? LO : IDLE) :
              state_q == LO   ? (last ? HI : LO) :
              state_q == HI   ? (last ? DONE : HI) : IDLE;
  end
  always_comb begin
    dir_wr_d = start ? wrEn : dir_wr_q;
    word_d = start ? word_of(address, 32'(BASE_ADDR)) : word_q;
    wdata_d = start ? writeData : wdata_q;
    addr_d = start ? {word_of(address, 32'(BASE_ADDR)), 1'b0} : to_hi ? {word_q, 1'b1} : addr_q;
    rdata_d = (dir_wr_q || !last) ? rdata_q :
              state_q == LO ? {rdata_q[31:16], SRAM_DQ} :
              state_q == HI ? {SRAM_DQ, rdata_q[15:0]} : rdata_q;
  end
  always_comb begin
    active = state_q == LO || state_q == HI;
    dq_oe = active && dir_wr_q;
    half = state_q == LO ? wdata_q[15:0] : wdata_q[31:16];
    SRAM_WE_N = !(dq_oe && we_window);
    SRAM_OE_N = !(active && !dir_wr_q);
    ready = (state_q == IDLE && !req) || state_q == DONE;
  end
  assign SRAM_DQ = dq_oe ? half : 'z;
  assign readData = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed stimulus with a scoreboard monitor against an SRAM behavioural model.
module tb_sram_controller;
  import sram_pkg::*;
  localparam int AC = 2;
  localparam int LAT = 2 * AC + 1;
  logic clk = 0, rst = 1, wrEn = 0, rdEn = 0;
  logic [31:0] address = 0, writeData = 0;
  wire [31:0] readData;
  wire ready, we_n, oe_n, ce_n, ub_n, lb_n;
  wire [15:0] dq;
  wire [17:0] sa;
  logic [15:0] mem [0:262143];
  int checks = 0, failures = 0, busy = 0, n = 0;
  logic [31:0] sb[$];
  logic [17:0] tr_addr [0:19];
  logic tr_we [0:19], tr_oe [0:19], tr_drv [0:19];
  logic [11:0] rdy_seq;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .address(address), .writeData(writeData),
    .readData(readData), .ready(ready), .SRAM_DQ(dq), .SRAM_ADDR(sa), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  assign dq = oe_n ? 16'hzzzz : mem[sa];
  always @(negedge clk) if (!we_n) mem[sa] = dq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) busy = 0;
    else if (wrEn || rdEn) begin
      if (!ready) busy++;
      else if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_completion actual=1 required=0");
      end else begin
        check("readData", readData, sb.pop_front());
        check("latency", busy, LAT);
        busy = 0;
      end
    end
  end

  task automatic go(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wrEn = wr; rdEn = rd; address = a; writeData = d;
  endtask

  task automatic trace_done();
    n = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tr_addr[i] = sa; tr_we[i] = we_n; tr_oe[i] = oe_n; tr_drv[i] = dut.dq_oe;
      if (ready) begin n = i; break; end
    end
    if (n < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=no_ready required=ready");
    end
    @(posedge clk); #1;
    wrEn = 0; rdEn = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
    mem[6] = 16'h5555;
    mem[7] = 16'hAAAA;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_readData", readData, 0);
    check("rst_addr", 32'(sa), 0);
    check("rst_we_oe", {30'd0, we_n, oe_n}, 3);
    check("rst_dq_drive", 32'(dut.dq_oe), 0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {28'd0, ready, oe_n, we_n, dut.dq_oe}, 32'he);
    end
    sb.push_back(32'h0);
    go(1, 0, 1024, 32'hDEADBEEF);
    trace_done();
    check("wr_ready_cycle", n, 5);
    check("wr_mem0", 32'(mem[0]), 32'hBEEF);
    check("wr_mem1", 32'(mem[1]), 32'hDEAD);
    check("wr_we_seq", {28'd0, tr_we[1], tr_we[2], tr_we[3], tr_we[4]}, 32'b0101);
    check("wr_oe_seq", {28'd0, tr_oe[1], tr_oe[2], tr_oe[3], tr_oe[4]}, 32'b1111);
    check("wr_drive_seq", {28'd0, tr_drv[1], tr_drv[2], tr_drv[3], tr_drv[4]}, 32'b1111);
    check("wr_addr_seq", {tr_addr[1][7:0], tr_addr[2][7:0], tr_addr[3][7:0], tr_addr[4][7:0]}, 32'h00000101);
    sb.push_back(32'hDEADBEEF);
    go(0, 1, 1024, 0);
    trace_done();
    check("rd_ready_cycle", n, 5);
    sb.push_back(32'hAAAA5555);
    go(0, 1, 1036, 0);
    trace_done();
    check("map_addr_seq", {tr_addr[1][7:0], tr_addr[2][7:0], tr_addr[3][7:0], tr_addr[4][7:0]}, 32'h06060707);
    check("map_oe_seq", {28'd0, tr_oe[1], tr_oe[2], tr_oe[3], tr_oe[4]}, 32'b0000);
    check("map_we_seq", {28'd0, tr_we[1], tr_we[2], tr_we[3], tr_we[4]}, 32'b1111);
    check("map_drive_seq", {28'd0, tr_drv[1], tr_drv[2], tr_drv[3], tr_drv[4]}, 32'b0000);
    sb.push_back(32'hAAAA5555);
    go(1, 1, 1028, 32'h12345678);
    @(negedge clk);
    @(posedge clk); #1;
    address = 2000; writeData = 32'hFFFFFFFF;
    trace_done();
    check("frz_mem2", 32'(mem[2]), 32'h5678);
    check("frz_mem3", 32'(mem[3]), 32'h1234);
    check("frz_ignored_addr", {mem[488], mem[489]}, 0);
    check("frz_readData", readData, 32'hAAAA5555);
    sb.push_back(32'hDEADBEEF);
    sb.push_back(32'hDEADBEEF);
    go(0, 1, 1024, 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rdy_seq[c] = ready;
    end
    @(posedge clk); #1;
    rdEn = 0;
    check("held_ready_pulses", 32'(rdy_seq), 32'b1000_0010_0000);
    go(1, 0, 1040, 32'hCAFEF00D);
    repeat (4) @(posedge clk);
    #1 rst = 1; wrEn = 0;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rstA_state", 32'(dut.state_q), 32'(IDLE));
    check("rstA_we_n", 32'(we_n), 1);
    check("rstA_dq_drive", 32'(dut.dq_oe), 0);
    check("rstA_readData", readData, 0);
    check("rstA_addr", 32'(sa), 0);
    check("rstA_mem8", 32'(mem[8]), 32'hF00D);
    go(1, 0, 1048, 32'h11112222);
    repeat (2) @(posedge clk);
    #1 rst = 1; wrEn = 0;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rstB_mem12", 32'(mem[12]), 32'h2222);
    check("rstB_mem13", 32'(mem[13]), 0);
    check("rstB_ready", 32'(ready), 1);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
